cla_16_bit_pipelined: RTL

- 16-bit adder built from four 4-bit augmented CLA slices. Each slice exports block propagate (BP) and block generate (BG).
- This block is the downstream consumer of those slice BP/BG outputs. It adds a registered second-level lookahead carry unit and a 2-stage valid/ready pipeline.
- It is the datapath adder feeding the ALU result mux.

---
 rtl/cla_16_bit_pipelined.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/cla_16_bit_pipelined.sv
// cla_16_bit_pipelined: WIDTH-bit adder built from 4-bit CLA slices with a
// second-level lookahead carry unit and a valid/ready pipeline.
// LCU_REG=1 registers operands and slice BP/BG ahead of the LCU (two stages);
// LCU_REG=0 feeds the LCU straight from the inputs (one stage).
// Optional macro CLA_OVERFLOW_FLAG_EN adds a registered signed-overflow flag.
module cla_16_bit_pipelined #(
  parameter int WIDTH   = 16,
  parameter int LCU_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / 4;

  logic              s2_load;
  logic              in_xfer;
  logic [NSLICE-1:0] in_bp;
  logic [NSLICE-1:0] in_bg;

  logic [WIDTH-1:0]  lcu_a;
  logic [WIDTH-1:0]  lcu_b;
  logic              lcu_cin;
  logic [NSLICE-1:0] lcu_bp;
  logic [NSLICE-1:0] lcu_bg;
  logic              lcu_fire;

  logic              out_valid_q;
  logic [WIDTH-1:0]  sum_q;
  logic [WIDTH-1:0]  sum_d;
  logic              cout_q;
  logic              cout_d;
`ifdef CLA_OVERFLOW_FLAG_EN
  logic              ovf_q;
  logic              ovf_d;
`endif

  assign s2_load = !out_valid_q || out_ready;
  assign in_xfer = in_valid && in_ready;

  // Slice-level block propagate / generate from the raw operands
  always_comb begin
    logic [3:0] p;
    logic [3:0] g;
    in_bp = '0;
    in_bg = '0;
    for (int s = 0; s < NSLICE; s++) begin
      p = a[4*s +: 4] ^ b[4*s +: 4];
      g = a[4*s +: 4] & b[4*s +: 4];
      in_bp[s] = &p;
      in_bg[s] = g[3] | (p[3] & (g[2] | (p[2] & (g[1] | (p[1] & g[0])))));
    end
  end

  if (LCU_REG != 0) begin : g_s1
    logic              s1_valid_q;
    logic [WIDTH-1:0]  s1_a_q;
    logic [WIDTH-1:0]  s1_b_q;
    logic              s1_cin_q;
    logic [NSLICE-1:0] s1_bp_q;
    logic [NSLICE-1:0] s1_bg_q;

    assign in_ready = !rst && (!s1_valid_q || s2_load);
    assign lcu_fire = s1_valid_q && s2_load;
    assign lcu_a    = s1_a_q;
    assign lcu_b    = s1_b_q;
    assign lcu_cin  = s1_cin_q;
    assign lcu_bp   = s1_bp_q;
    assign lcu_bg   = s1_bg_q;

    // Stage 1: capture operands and slice BP/BG on input transfer
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_valid_q <= 1'b0;
        s1_a_q     <= '0;
        s1_b_q     <= '0;
        s1_cin_q   <= 1'b0;
        s1_bp_q    <= '0;
        s1_bg_q    <= '0;
      end else if (in_xfer) begin
        s1_valid_q <= 1'b1;
        s1_a_q     <= a;
        s1_b_q     <= b;
        s1_cin_q   <= cin;
        s1_bp_q    <= in_bp;
        s1_bg_q    <= in_bg;
      end else if (lcu_fire) begin
        s1_valid_q <= 1'b0;
      end
    end
  end else begin : g_no_s1
    assign in_ready = !rst && s2_load;
    assign lcu_fire = in_xfer;
    assign lcu_a    = a;
    assign lcu_b    = b;
    assign lcu_cin  = cin;
    assign lcu_bp   = in_bp;
    assign lcu_bg   = in_bg;
  end

  // Lookahead carry unit: slice carries as flat sum-of-products, then per-slice sums
  always_comb begin
    logic [NSLICE:0] c;
    logic            prod;
    logic            kc;
    logic            pk;
    logic            gk;
`ifdef CLA_OVERFLOW_FLAG_EN
    logic            msb_c;
    msb_c = 1'b0;
`endif
    c     = '0;
    prod  = 1'b0;
    kc    = 1'b0;
    pk    = 1'b0;
    gk    = 1'b0;
    sum_d = '0;
    c[0]  = lcu_cin;
    for (int i = 0; i < NSLICE; i++) begin
      c[i+1] = lcu_bg[i];
      prod   = lcu_bp[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (prod & lcu_bg[j]);
        prod   = prod & lcu_bp[j];
      end
      c[i+1] = c[i+1] | (prod & lcu_cin);
    end
    for (int s = 0; s < NSLICE; s++) begin
      kc = c[s];
      for (int k = 0; k < 4; k++) begin
        pk = lcu_a[4*s+k] ^ lcu_b[4*s+k];
        gk = lcu_a[4*s+k] & lcu_b[4*s+k];
        sum_d[4*s+k] = pk ^ kc;
`ifdef CLA_OVERFLOW_FLAG_EN
        if (4*s + k == WIDTH - 1) msb_c = kc;
`endif
        kc = gk | (pk & kc);
      end
    end
    cout_d = c[NSLICE];
`ifdef CLA_OVERFLOW_FLAG_EN
    ovf_d = msb_c ^ c[NSLICE];
`endif
  end

  // Stage 2: result register; holds under backpressure, sum/cout kept on drain
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
`ifdef CLA_OVERFLOW_FLAG_EN
      ovf_q       <= 1'b0;
`endif
    end else if (lcu_fire) begin
      out_valid_q <= 1'b1;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
`ifdef CLA_OVERFLOW_FLAG_EN
      ovf_q       <= ovf_d;
`endif
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Suppress any output transfer during the reset cycle itself
  assign out_valid = out_valid_q && !rst;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef CLA_OVERFLOW_FLAG_EN
  assign ovf       = ovf_q;
`endif

endmodule
